mem_responder: RTL and testbench

- Memory-side responder for the datapath's MAR/MDR interface.
- Accepts read and write requests:
  - address taken from MAR output;
  - write data taken from MDR output.
- Performs the access on an internal word-addressed RAM after a configurable number of wait states.
- Returns read data on MdataIn, which feeds the MDR's memory input, plus a one-cycle completion pulse for the control unit.

---
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM responder behind the MAR/MDR interface; one request at a time, error on bad requests.
// Latency: accept at edge N, mem_ready high in the cycle after edge N+WAIT_STATES; busy until back in IDLE.
// Backpressure: no queuing; requests are sampled only in IDLE, and a request held high is re-accepted after DONE.
module mem_responder #(
   parameter int ADDR_WIDTH  = 9,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           addr_in,
   input  logic [DATA_WIDTH-1:0] wdata_in,
   input  logic                  rd_req,
   input  logic                  wr_req,
   output logic [DATA_WIDTH-1:0] MdataIn,
   output logic                  mem_ready,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam int         DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   lat_idx;
   logic                    lat_oor;
   logic                    lat_wr;
   logic [DATA_WIDTH-1:0]   lat_data;

   logic [DATA_WIDTH-1:0]   ram [0:DEPTH-1];

   logic                    in_idle;
   logic                    accept;
   logic                    conflict;
   logic                    enter_done;
   logic [ADDR_WIDTH-1:0]   acc_idx;
   logic                    acc_oor;
   logic                    acc_wr;
   logic [DATA_WIDTH-1:0]   acc_data;

   // Access operands: with zero wait states the access happens on the accepting
   // edge itself, so the live inputs are used instead of the (not yet loaded) latches.
   always_comb begin
      in_idle    = (state_q == S_IDLE);
      accept     = in_idle && (rd_req ^ wr_req);
      conflict   = in_idle && rd_req && wr_req;
      acc_idx    = in_idle ? addr_in[ADDR_WIDTH-1:0] : lat_idx;
      acc_oor    = in_idle ? (|addr_in[31:ADDR_WIDTH]) : lat_oor;
      acc_wr     = in_idle ? wr_req : lat_wr;
      acc_data   = in_idle ? wdata_in : lat_data;
      enter_done = (accept && (WAIT_STATES == 0)) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd1));
   end

   // Next-state and wait counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WS_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Completion and busy are pure state decodes so reset clears them immediately.
   assign mem_ready = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);

   // State, request latches, error flag and read data register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         lat_idx  <= '0;
         lat_oor  <= 1'b0;
         lat_wr   <= 1'b0;
         lat_data <= '0;
         err      <= 1'b0;
         MdataIn  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            lat_idx <= addr_in[ADDR_WIDTH-1:0];
            lat_oor <= |addr_in[31:ADDR_WIDTH];
            lat_wr  <= wr_req;
            if (wr_req) lat_data <= wdata_in;
         end
         err <= conflict || (enter_done && acc_oor);
         if (enter_done && !acc_wr) MdataIn <= acc_oor ? '0 : ram[acc_idx];
      end
   end

   // RAM write port; contents survive reset, and an aborted request never reaches here
   // because reset forces the state back to IDLE.
   always_ff @(posedge clk) begin
      if (enter_done && acc_wr && !acc_oor) ram[acc_idx] <= acc_data;
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int WS = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr_in = '0, wdata_in = '0;
   logic        rd_req = 1'b0, wr_req = 1'b0;
   logic [31:0] MdataIn;
   logic        mem_ready, busy, err;

   logic [31:0] addr0 = '0, wdata0 = '0;
   logic        rd0 = 1'b0, wr0 = 1'b0;
   logic [31:0] mdata0;
   logic        ready0, busy0, err0;

   int checks = 0;
   int errors = 0;

   // reference model: plain word array plus last read value
   logic [31:0] mem_m [0:511];
   logic [31:0] mdata_m = '0;

   mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .addr_in(addr_in), .wdata_in(wdata_in),
      .rd_req(rd_req), .wr_req(wr_req), .MdataIn(MdataIn),
      .mem_ready(mem_ready), .busy(busy), .err(err));

   mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .addr_in(addr0), .wdata_in(wdata0),
      .rd_req(rd0), .wr_req(wr0), .MdataIn(mdata0),
      .mem_ready(ready0), .busy(busy0), .err(err0));

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_md;
      logic        exp_err;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one request on the WS=2 instance, from IDLE back to IDLE, then model update
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_md, input logic exp_err);
      int cyc;
      logic oor;
      rd_req = rd; wr_req = wr; addr_in = addr; wdata_in = data;
      step();
      rd_req = 1'b0; wr_req = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      cyc = 0;
      while (!mem_ready && cyc < 20) begin
         step();
         cyc++;
      end
      chk("latency", cyc, WS);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_err", {31'd0, err}, {31'd0, exp_err});
      chk("done_mdata", MdataIn, exp_md);
      step();
      chk("ready_width", {31'd0, mem_ready}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_err", {31'd0, err}, 32'd0);
      oor = (addr[31:9] != 23'd0);
      if (rd) mdata_m = oor ? 32'd0 : mem_m[addr[8:0]];
      else if (!oor) mem_m[addr[8:0]] = data;
   endtask

   initial begin
      int cyc;
      logic        r, oor;
      logic [31:0] a, d, emd;

      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_000A, 32'h1234_5678, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_000A, 32'h0,         32'h1234_5678, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h0707_0707, 32'h1234_5678, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h2020_2020, 32'h1234_5678, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h0000_0005, 32'h55AA_55AA, 32'h1234_5678, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 32'h0000_0200, 32'hBAD0_BAD0, 32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0007, 32'h0,         32'h0707_0707, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 1'b1};

      // reset state
      #2;
      chk("rst_mdata", MdataIn, 32'd0);
      chk("rst_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      step(); step();
      reset = 1'b1;
      step();

      // directed table
      for (int i = 0; i < 11; i++)
         do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_md, vecs[i].exp_err);

      // conflicting request: error pulse only
      rd_req = 1'b1; wr_req = 1'b1; addr_in = 32'h7; wdata_in = 32'hFFFF_0000;
      step();
      rd_req = 1'b0; wr_req = 1'b0;
      chk("conf_err", {31'd0, err}, 32'd1);
      chk("conf_ready", {31'd0, mem_ready}, 32'd0);
      chk("conf_busy", {31'd0, busy}, 32'd0);
      step();
      chk("conf_err_clear", {31'd0, err}, 32'd0);
      chk("conf_mdata", MdataIn, mdata_m);
      do_req(1'b1, 1'b0, 32'h7, 32'h0, 32'h0707_0707, 1'b0);

      // reset aborts a write in WAIT
      wr_req = 1'b1; addr_in = 32'h5; wdata_in = 32'hDEAD_BEEF;
      step();
      wr_req = 1'b0;
      step();
      reset = 1'b0;
      #1;
      chk("abort_ready", {31'd0, mem_ready}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_err", {31'd0, err}, 32'd0);
      chk("abort_mdata", MdataIn, 32'd0);
      step(); step();
      reset = 1'b1;
      mdata_m = 32'd0;
      cyc = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (mem_ready) cyc++;
      end
      chk("abort_no_ready", cyc, 0);
      do_req(1'b1, 1'b0, 32'h5, 32'h0, 32'h55AA_55AA, 1'b0);

      // request changes during WAIT are ignored; held request re-accepted after DONE
      rd_req = 1'b1; addr_in = 32'h0A;
      step();
      rd_req = 1'b0;
      step();
      rd_req = 1'b1; addr_in = 32'h20;
      step();
      chk("hold_ready", {31'd0, mem_ready}, 32'd1);
      chk("hold_mdata", MdataIn, 32'h1234_5678);
      step();
      chk("hold_idle_busy", {31'd0, busy}, 32'd0);
      step();
      chk("hold_reaccept", {31'd0, busy}, 32'd1);
      rd_req = 1'b0;
      cyc = 0;
      while (!mem_ready && cyc < 20) begin
         step();
         cyc++;
      end
      chk("hold_latency", cyc, WS);
      chk("hold_mdata2", MdataIn, 32'h2020_2020);
      step();
      mdata_m = 32'h2020_2020;

      // randomized traffic against the model
      for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, i, $urandom, mdata_m, 1'b0);
      for (int i = 0; i < 60; i++) begin
         r = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) a = (32'h200 << $urandom_range(0, 22)) | $urandom_range(0, 15);
         else a = $urandom_range(0, 15);
         d = $urandom;
         oor = (a[31:9] != 23'd0);
         emd = r ? (oor ? 32'd0 : mem_m[a[8:0]]) : mdata_m;
         do_req(r, !r, a, d, emd, oor);
      end

      // zero wait states
      wr0 = 1'b1; addr0 = 32'h3; wdata0 = 32'hCAFE_F00D;
      step();
      wr0 = 1'b0;
      chk("ws0_wr_ready", {31'd0, ready0}, 32'd1);
      step();
      chk("ws0_wr_idle", {31'd0, busy0}, 32'd0);
      rd0 = 1'b1;
      step();
      rd0 = 1'b0;
      chk("ws0_rd_ready", {31'd0, ready0}, 32'd1);
      chk("ws0_rd_busy", {31'd0, busy0}, 32'd1);
      chk("ws0_rd_mdata", mdata0, 32'hCAFE_F00D);
      chk("ws0_rd_err", {31'd0, err0}, 32'd0);
      step();
      chk("ws0_ready_width", {31'd0, ready0}, 32'd0);
      chk("ws0_busy_width", {31'd0, busy0}, 32'd0);
      chk("ws0_mdata_hold", mdata0, 32'hCAFE_F00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
